// File: rtl/dmem_responder.sv
// Data-memory target with programmable wait states in front of a
// byte-lane synchronous RAM; one request outstanding at a time.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 14,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter              INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned LW    = ADDR_WIDTH + 2;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [7:0]  WAIT_LOAD =
      (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [LW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    size_q, size_d;
   logic          write_q, write_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   rd_word_q;
   logic [ADDR_WIDTH-1:0] rd_idx;

   logic          req_err;
   logic          we;
   logic [3:0]    be;
   logic [1:0]    lane;
   logic [4:0]    sh_amt;
   logic [31:0]   wdata_sh;
   logic [31:0]   rd_sh;
   logic [31:0]   load_val;

   assign req_err = (req_size == 2'b11)
                  | ((req_size == 2'b01) & req_addr[0])
                  | ((req_size == 2'b10) & (|req_addr[1:0]))
                  | (req_addr[31:LW] != BASE_ADDR[31:LW]);

   assign lane     = addr_q[1:0];
   assign sh_amt   = {lane, 3'b000};
   assign wdata_sh = wdata_q << sh_amt;
   assign rd_sh    = rd_word_q >> sh_amt;

   always_comb begin
      be       = 4'b1111;
      load_val = rd_sh;
      unique case (size_q)
         2'b00: begin
            be       = 4'b0001 << lane;
            load_val = {24'd0, rd_sh[7:0]};
         end
         2'b01: begin
            be       = 4'b0011 << lane;
            load_val = {16'd0, rd_sh[15:0]};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      write_d    = write_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      we         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr[LW-1:0];
               wdata_d = req_wdata;
               size_d  = req_size;
               write_d = req_write;
               if (req_err) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end else if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 8'd0) state_d = S_ACCESS;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_ACCESS: begin
            state_d = S_RESP;
            err_d   = 1'b0;
            rdata_d = write_q ? 32'd0 : load_val;
            we      = write_q;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         size_q  <= 2'b00;
         write_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Read address tracks the incoming request in IDLE so the registered
   // word is already valid by the ACCESS cycle, even with zero wait states.
   assign rd_idx = (state_q == S_IDLE) ? req_addr[LW-1:2]
                                       : addr_q[LW-1:2];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr_q[LW-1:2]][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
      rd_word_q <= mem[rd_idx];
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states
// and one with none, sharing request fields but with separate valids.
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic        v2, v0;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  sz;
   logic        rr;

   logic        rdy2, rv2, er2, bz2;
   logic [31:0] rd2;
   logic        rdy0, rv0, er0, bz0;
   logic [31:0] rd0;

   int n_vec;
   int n_err;

   dmem_responder #(.WAIT_CYCLES(2)) u_dut2 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (v2),
      .req_ready  (rdy2),
      .req_write  (wr),
      .req_addr   (addr),
      .req_wdata  (wdata),
      .req_size   (sz),
      .resp_valid (rv2),
      .resp_ready (rr),
      .resp_rdata (rd2),
      .resp_err   (er2),
      .busy       (bz2)
   );

   dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (v0),
      .req_ready  (rdy0),
      .req_write  (wr),
      .req_addr   (addr),
      .req_wdata  (wdata),
      .req_size   (sz),
      .resp_valid (rv0),
      .resp_ready (rr),
      .resp_rdata (rd0),
      .resp_err   (er0),
      .busy       (bz0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input bit sel, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, output logic [31:0] rdat,
                       output logic e, output int lat);
      wr    = w;
      addr  = a;
      wdata = d;
      sz    = s;
      if (sel) v0 = 1'b1;
      else     v2 = 1'b1;
      tick();
      v0  = 1'b0;
      v2  = 1'b0;
      lat = 0;
      while (!(sel ? rv0 : rv2) && lat < 40) begin
         tick();
         lat++;
      end
      rdat = sel ? rd0 : rd2;
      e    = sel ? er0 : er2;
      rr   = 1'b1;
      tick();
      rr   = 1'b0;
   endtask

   task automatic run(input string tag, input bit sel, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic [31:0] xrd,
                      input logic xer, input int xlat);
      logic [31:0] rdat;
      logic        e;
      int          lat;
      xfer(sel, w, a, d, s, rdat, e, lat);
      check({tag, ".rd"}, rdat, xrd);
      check({tag, ".err"}, 32'(e), 32'(xer));
      check({tag, ".lat"}, 32'(lat), 32'(xlat));
   endtask

   initial begin
      int          lat;
      logic [8:0]  mask;
      int          nrv;
      logic        prev;

      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      v2 = 1'b0; v0 = 1'b0; wr = 1'b0; rr = 1'b0;
      addr = 32'd0; wdata = 32'd0; sz = 2'b00;

      repeat (2) tick();
      check("rst.rdy", 32'(rdy2), 32'd1);
      check("rst.rv", 32'(rv2), 32'd0);
      check("rst.rd", rd2, 32'd0);
      check("rst.err", 32'(er2), 32'd0);
      check("rst.busy", 32'(bz2), 32'd0);
      check("rst.rdy0", 32'(rdy0), 32'd1);
      reset = 1'b0;
      tick();

      run("st_w", 0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 32'd0, 0, 3);
      run("ld_w", 0, 0, 32'h8000_0010, 32'd0, 2'b10, 32'hDEAD_BEEF, 0, 3);
      run("st_b", 0, 1, 32'h8000_0011, 32'h1234_56AA, 2'b00, 32'd0, 0, 3);
      run("st_h", 0, 1, 32'h8000_0012, 32'hABCD_1234, 2'b01, 32'd0, 0, 3);
      run("ld_w2", 0, 0, 32'h8000_0010, 32'd0, 2'b10, 32'h1234_AAEF, 0, 3);
      run("ld_b3", 0, 0, 32'h8000_0013, 32'd0, 2'b00, 32'h0000_0012, 0, 3);
      run("ld_h2", 0, 0, 32'h8000_0012, 32'd0, 2'b01, 32'h0000_1234, 0, 3);
      run("st_w0", 0, 1, 32'h8000_0000, 32'h1122_3344, 2'b10, 32'd0, 0, 3);
      run("st_top", 0, 1, 32'h8000_FFFC, 32'hA5A5_5A5A, 2'b10, 32'd0, 0, 3);
      run("ld_top", 0, 0, 32'h8000_FFFC, 32'd0, 2'b10, 32'hA5A5_5A5A, 0, 3);
      run("ld_b1", 0, 0, 32'h8000_0011, 32'd0, 2'b00, 32'h0000_00AA, 0, 3);

      run("e_half", 0, 0, 32'h8000_0001, 32'd0, 2'b01, 32'd0, 1, 0);
      run("e_word", 0, 1, 32'h8000_0002, 32'hFFFF_FFFF, 2'b10, 32'd0, 1, 0);
      run("e_size", 0, 0, 32'h8000_0010, 32'd0, 2'b11, 32'd0, 1, 0);
      run("e_base", 0, 1, 32'h0000_0000, 32'hCAFE_F00D, 2'b10, 32'd0, 1, 0);
      run("e_hi", 0, 0, 32'h8001_0000, 32'd0, 2'b10, 32'd0, 1, 0);
      run("chk0", 0, 0, 32'h8000_0000, 32'd0, 2'b10, 32'h1122_3344, 0, 3);
      run("chk1", 0, 0, 32'h8000_0010, 32'd0, 2'b10, 32'h1234_AAEF, 0, 3);

      // Backpressure with a second request queued behind the response.
      wr = 1'b0; addr = 32'h8000_0010; sz = 2'b10; v2 = 1'b1;
      tick();
      v2  = 1'b0;
      lat = 0;
      while (!rv2 && lat < 40) begin
         tick();
         lat++;
      end
      check("bp.lat", 32'(lat), 32'd3);
      addr = 32'h8000_0000;
      v2   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp.rv", 32'(rv2), 32'd1);
         check("bp.rd", rd2, 32'h1234_AAEF);
         check("bp.rdy", 32'(rdy2), 32'd0);
      end
      rr = 1'b1;
      tick();
      rr = 1'b0;
      check("bp.rv_off", 32'(rv2), 32'd0);
      check("bp.idle", 32'(bz2), 32'd0);
      check("bp.rdy_on", 32'(rdy2), 32'd1);
      tick();
      check("bp.accept", 32'(bz2), 32'd1);
      v2  = 1'b0;
      lat = 0;
      while (!rv2 && lat < 40) begin
         tick();
         lat++;
      end
      check("bp2.lat", 32'(lat), 32'd3);
      check("bp2.rd", rd2, 32'h1122_3344);
      rr = 1'b1;
      tick();
      rr = 1'b0;

      // Reset while a store sits in WAIT.
      run("st_20", 0, 1, 32'h8000_0020, 32'h0BAD_C0DE, 2'b10, 32'd0, 0, 3);
      run("ld_20", 0, 0, 32'h8000_0020, 32'd0, 2'b10, 32'h0BAD_C0DE, 0, 3);
      wr = 1'b1; addr = 32'h8000_0020; wdata = 32'h5555_5555; sz = 2'b10;
      v2 = 1'b1;
      tick();
      v2 = 1'b0;
      check("rw.busy", 32'(bz2), 32'd1);
      check("rw.pre_rd", rd2, 32'h0BAD_C0DE);
      #2 reset = 1'b1;
      #1;
      check("rw.busy0", 32'(bz2), 32'd0);
      check("rw.rdy", 32'(rdy2), 32'd1);
      check("rw.rv", 32'(rv2), 32'd0);
      check("rw.rd", rd2, 32'd0);
      check("rw.err", 32'(er2), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      run("ld_20b", 0, 0, 32'h8000_0020, 32'd0, 2'b10, 32'h0BAD_C0DE, 0, 3);

      // Zero wait states.
      run("w0.st", 1, 1, 32'h8000_0004, 32'h600D_F00D, 2'b10, 32'd0, 0, 1);
      run("w0.ld", 1, 0, 32'h8000_0004, 32'd0, 2'b10, 32'h600D_F00D, 0, 1);
      run("w0.err", 1, 0, 32'h8000_0006, 32'd0, 2'b10, 32'd0, 1, 0);

      wr = 1'b0; addr = 32'h8000_0004; sz = 2'b10;
      v0 = 1'b1; rr = 1'b1;
      mask = '0;
      nrv  = 0;
      prev = bz0;
      for (int t = 0; t < 9; t++) begin
         tick();
         if (!prev && bz0) mask[t] = 1'b1;
         if (rv0) nrv++;
         prev = bz0;
      end
      v0 = 1'b0;
      rr = 1'b0;
      tick();
      check("b2b.accepts", 32'(mask), 32'h049);
      check("b2b.resps", 32'(nrv), 32'd3);
      check("b2b.rd", rd0, 32'h600D_F00D);
      check("b2b.idle", 32'(bz0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
